sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
Parametrised synchronous FIFO and successor to the team's fixed single-mode FIFO.
- Width and depth are generalised.
- Two read modes, selected by parameter: registered-read standard, and first-word-fall-through (FWFT).
- Adds occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer datapaths in a single clock domain.

Parameters:
- DATA_W, 8: data word width in bits.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W entries.
- AF_LEVEL, 12: almost_full asserts when count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL. Legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents and pointers.
- wr_en  input  1  write request.
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read/pop request.
- rd_data  output  DATA_W  read data.
- rd_valid  output  1  rd_data qualifier.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was rejected.
- underflow  output  1  sticky: a read was rejected.
- err_clr  input  1  clears overflow and underflow.

Behaviour:
- Reset is synchronous, active-high, clock clk. rst has priority over every other input.
- Values after reset:
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1 (AE_LEVEL >= 0), almost_full = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
- Storage array is not reset.
- Pointers are ADDR_W bits and wrap naturally at DEPTH. count is a separate ADDR_W+1 bit register.
- Flags are combinational decodes of the registered count, so they change in the same cycle as count.
- Write accepted (wr_ok) = wr_en & (!full | rd_ok).
  - A write to a full FIFO succeeds only when a read is accepted in the same cycle.
- Read accepted (rd_ok) = rd_en & !empty.
  - No bypass: a read while empty is rejected even if wr_en is high.
- Per edge:
  - wr_ok: mem[wr_ptr] <= wr_data, wr_ptr += 1.
  - rd_ok: rd_ptr += 1.
  - count += wr_ok - rd_ok; simultaneous accepted read and write leaves count unchanged.
- FWFT = 0:
  - rd_ok loads rd_data <= mem[rd_ptr] and sets rd_valid = 1 on the next cycle. Latency is 1 cycle.
  - rd_valid is a one-cycle pulse per accepted read.
  - rd_data holds its last value when no read is accepted.
- FWFT = 1:
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en acts as a pop/acknowledge.
  - A word written into an empty FIFO appears on rd_data one cycle after the write edge.
- Flush (when rst is low):
  - Pointers and count go to 0; rd_valid goes to 0.
  - wr_en and rd_en in the same cycle are ignored and do not set error flags.
  - overflow and underflow are preserved.
- Error flags:
  - overflow is set when wr_en & !wr_ok.
  - underflow is set when rd_en & !rd_ok.
  - Both are cleared by err_clr. A set in the same cycle as err_clr wins.
  - Neither flag affects data movement.
- Illegal AF_LEVEL/AE_LEVEL values must be flagged by an elaboration-time check.

Decomposition:
- Shared package fifo_pkg holds:
  - Depth and count-width helper functions: depth from ADDR_W, count width ADDR_W+1.
  - A mode constant enumeration: FIFO_STD = 0, FIFO_FWFT = 1.
- Natural sub-module: fifo_dpram, a simple dual-port array with one write port and an asynchronous read port, parametrised by DATA_W and ADDR_W.
- The top level holds pointers, count, flags, the read register and error logic.

Test Plan:
- Fill/drain, FWFT=0: write 0x00..0x0F over 16 cycles. Check:
  - full = 1 and count = 16; almost_full first rises when count = 12.
  - Then read 16 words: rd_valid pulses one cycle after each rd_en, data 0x00..0x0F in order, empty = 1 at end.
- Overflow: with the FIFO full, wr_en = 1 alone gives overflow = 1, count stays 16, and the head word is unchanged. err_clr = 1 clears it the next cycle.
- Simultaneous read and write:
  - Full with rd_en = wr_en = 1 (wr_data 0xAA): count stays 16 and 0xAA is read out 16th after subsequent drain.
  - Empty with rd_en = wr_en = 1: write accepted, underflow = 1, count = 1.
- FWFT=1: write 0x5A into an empty FIFO. rd_valid = 1 and rd_data = 0x5A on the next cycle with no rd_en. rd_en pop returns empty = 1.
- Wrap-around: write 10, read 10, then write 10 with data 0x20..0x29 and read 10. Data is in order with no loss across the pointer wrap.
- Flush and reset mid-operation:
  - At count = 7, flush together with wr_en gives count = 0 and empty = 1, with no overflow set.
  - rst asserted with overflow = 1 clears every output to its reset value.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the sync_fifo_flex family: read-mode enumeration and
// helpers that derive storage depth and occupancy-counter width from ADDR_W.
// -----------------------------------------------------------------------------
package fifo_pkg;

  // Read-port behaviour of the FIFO.
  typedef enum logic {
    FIFO_STD  = 1'b0,  // registered read, one cycle latency
    FIFO_FWFT = 1'b1   // first-word-fall-through
  } fifo_mode_e;

  // Number of storage entries for a given pointer width.
  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Occupancy needs one extra bit so that a full FIFO (DEPTH) is representable.
  function automatic int unsigned fifo_cnt_w(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// -----------------------------------------------------------------------------
// fifo_dpram
// Simple dual-port storage: one synchronous write port, one asynchronous read
// port. Contents are not reset.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   [ADDR_W]  write address
//   wdata  in   [DATA_W]  write data
//   raddr  in   [ADDR_W]  read address
//   rdata  out  [DATA_W]  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fifo_dpram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  import fifo_pkg::*;

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex
// Parametrised single-clock FIFO with standard (registered) or
// first-word-fall-through read, occupancy count, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset, highest priority
//   flush         in   synchronous clear of pointers/count (keeps error flags)
//   wr_en         in   write request
//   wr_data       in   [DATA_W] write data
//   rd_en         in   read / pop request
//   rd_data       out  [DATA_W] read data
//   rd_valid      out  rd_data qualifier
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  [ADDR_W+1] occupancy 0..DEPTH
//   overflow      out  sticky: a write was rejected
//   underflow     out  sticky: a read was rejected
//   err_clr       in   clears overflow/underflow (a same-cycle set wins)
// -----------------------------------------------------------------------------
module sync_fifo_flex #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  import fifo_pkg::*;

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);
  localparam int unsigned CNT_W = fifo_cnt_w(ADDR_W);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  localparam fifo_mode_e MODE = fifo_mode_e'(FWFT[0]);

  // Elaboration-time legality checks on the threshold and mode parameters.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_flex: AF_LEVEL=%0d outside legal range 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flex: AE_LEVEL=%0d outside legal range 0..%0d", AE_LEVEL, DEPTH - 1);
  end
  if (FWFT > 1) begin : g_bad_mode
    $error("sync_fifo_flex: FWFT=%0d must be 0 or 1", FWFT);
  end

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] mem_rdata;

  logic rd_ok_raw;
  logic wr_ok_raw;
  logic rd_ok;
  logic wr_ok;
  logic ovf_set;
  logic unf_set;

  // Flags are plain decodes of the registered occupancy.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;

  // Acceptance: no read-through-empty bypass; a full FIFO takes a write only
  // alongside an accepted read. Flush suppresses both and any error.
  assign rd_ok_raw = rd_en & ~empty;
  assign wr_ok_raw = wr_en & (~full | rd_ok_raw);
  assign rd_ok     = rd_ok_raw & ~flush;
  assign wr_ok     = wr_ok_raw & ~flush;
  assign ovf_set   = wr_en & ~wr_ok_raw & ~flush;
  assign unf_set   = rd_en & ~rd_ok_raw & ~flush;

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (unf_set) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  // Read port.
  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Registered read: one-cycle valid pulse per accepted read, data held otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_ok;
        if (rd_ok) begin
          data_q <= mem_rdata;
        end
      end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;
  end else begin : g_fwft
    // Head word shown directly; forced to zero while empty so the
    // unreset storage never leaks out and reset reads back as zero.
    assign rd_data  = empty ? '0 : mem_rdata;
    assign rd_valid = ~empty;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flex
// Drives one standard-mode and one FWFT-mode sync_fifo_flex with identical
// stimulus. A queue-based reference model tracks contents and error flags;
// accepted standard-mode reads push expected data into a scoreboard that a
// negedge monitor drains whenever rd_valid is seen.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flex;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;
  localparam int unsigned AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          err_clr;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rd_valid, f_rd_valid;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_af, f_af, s_ae, f_ae;
  logic [AW:0]   s_count, f_count;
  logic          s_ovf, f_ovf, s_unf, f_unf;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf),
    .underflow(s_unf), .err_clr(err_clr)
  );

  sync_fifo_flex #(.DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_unf), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mq[$];     // reference FIFO contents, head at index 0
  logic [DW-1:0] exp_q[$];  // expected standard-mode read data
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the same edge as the DUTs.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit f, input bit ec, input bit rs);
    bit rok, wok;
    wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = ec; rst = rs;
    rok = r && (mq.size() != 0);
    wok = w && ((mq.size() < DEPTH) || rok);
    @(posedge clk);
    if (rs) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (f) begin
        mq.delete();
      end else begin
        if (rok) exp_q.push_back(mq.pop_front());
        if (wok) mq.push_back(d);
      end
      if (!f && w && !wok) m_ovf = 1'b1;
      else if (ec)         m_ovf = 1'b0;
      if (!f && r && !rok) m_unf = 1'b1;
      else if (ec)         m_unf = 1'b0;
    end
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d); cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic rd();                        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic idle();                      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_reset();                  cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); endtask

  // Monitor: status of both DUTs against the model, read data via scoreboard.
  always @(negedge clk) begin
    int c;
    logic [DW-1:0] e;
    if (mon_en) begin
      c = mq.size();
      chk("std.count",        32'(s_count), 32'(c));
      chk("fwft.count",       32'(f_count), 32'(c));
      chk("std.full",         32'(s_full),  32'(c == DEPTH));
      chk("fwft.full",        32'(f_full),  32'(c == DEPTH));
      chk("std.empty",        32'(s_empty), 32'(c == 0));
      chk("fwft.empty",       32'(f_empty), 32'(c == 0));
      chk("std.almost_full",  32'(s_af),    32'(c >= AF));
      chk("fwft.almost_full", 32'(f_af),    32'(c >= AF));
      chk("std.almost_empty", 32'(s_ae),    32'(c <= AE));
      chk("fwft.almost_empty",32'(f_ae),    32'(c <= AE));
      chk("std.overflow",     32'(s_ovf),   32'(m_ovf));
      chk("fwft.overflow",    32'(f_ovf),   32'(m_ovf));
      chk("std.underflow",    32'(s_unf),   32'(m_unf));
      chk("fwft.underflow",   32'(f_unf),   32'(m_unf));
      chk("std.rd_valid",     32'(s_rd_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (s_rd_valid) chk("std.rd_data", 32'(s_rd_data), 32'(e));
      end
      chk("fwft.rd_valid", 32'(f_rd_valid), 32'(c != 0));
      if (c != 0) chk("fwft.rd_data", 32'(f_rd_data), 32'(mq[0]));
    end
  end

  // Safety net against a hung run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;

    // Reset values.
    do_reset();
    do_reset();
    mon_en = 1'b1;
    chk("reset.std.rd_data",  32'(s_rd_data), 32'h0);
    chk("reset.fwft.rd_data", 32'(f_rd_data), 32'h0);
    chk("reset.std.rd_valid", 32'(s_rd_valid), 32'h0);
    chk("reset.std.ae",       32'(s_ae), 32'h1);

    // Fill 0x00..0x0F; almost_full tracked every cycle by the monitor.
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill.full",  32'(s_full),  32'h1);
    chk("fill.count", 32'(s_count), 32'd16);

    // Overflow while full, then clear.
    wr(8'hEE);
    chk("ovf.set",   32'(s_ovf),   32'h1);
    chk("ovf.count", 32'(s_count), 32'd16);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf.clr", 32'(s_ovf), 32'h0);

    // Drain: data 0x00..0x0F in order; rd_data then holds the last word.
    for (int i = 0; i < 16; i++) rd();
    idle();
    chk("drain.empty", 32'(s_empty),   32'h1);
    chk("drain.hold",  32'(s_rd_data), 32'h0F);

    // Full with simultaneous read and write of 0xAA, then drain.
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("simul.full.count", 32'(s_count), 32'd16);
    for (int i = 0; i < 16; i++) rd();
    idle();
    chk("simul.last", 32'(s_rd_data), 32'hAA);

    // Empty with simultaneous read and write.
    cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("simul.empty.unf",   32'(s_unf),   32'h1);
    chk("simul.empty.count", 32'(s_count), 32'd1);
    chk("fwft.fallthrough",  32'(f_rd_data), 32'h5A);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    rd();
    chk("fwft.pop.empty", 32'(f_empty), 32'h1);

    // FWFT: a word written into empty appears next cycle without rd_en.
    wr(8'h5A);
    chk("fwft.valid", 32'(f_rd_valid), 32'h1);
    chk("fwft.data",  32'(f_rd_data),  32'h5A);
    rd();
    idle();

    // Wrap-around across the pointer boundary.
    for (int i = 0; i < 10; i++) wr(8'(8'h10 + i));
    for (int i = 0; i < 10; i++) rd();
    for (int i = 0; i < 10; i++) wr(8'(8'h20 + i));
    for (int i = 0; i < 10; i++) rd();
    idle();
    chk("wrap.last", 32'(s_rd_data), 32'h29);

    // Flush at count 7 together with wr_en: no overflow, FIFO cleared.
    for (int i = 0; i < 7; i++) wr(8'(8'h70 + i));
    cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush.count", 32'(s_count), 32'd0);
    chk("flush.ovf",   32'(s_ovf),   32'h0);

    // Reset with overflow pending clears everything.
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
    wr(8'h11);
    rd();
    chk("prerst.ovf", 32'(s_ovf), 32'h1);
    do_reset();
    chk("rst.std.rd_data", 32'(s_rd_data), 32'h0);
    chk("rst.ovf",         32'(s_ovf),     32'h0);
    chk("rst.count",       32'(s_count),   32'h0);

    // Randomized traffic in write-heavy, read-heavy and balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      int wp, rp;
      wp = (ph == 0) ? 75 : (ph == 1) ? 30 : 50;
      rp = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
      for (int i = 0; i < 700; i++) begin
        bit w, r, f, ec, rs;
        w  = ($urandom_range(0, 99) < wp);
        r  = ($urandom_range(0, 99) < rp);
        f  = ($urandom_range(0, 99) < 2);
        ec = ($urandom_range(0, 99) < 4);
        rs = ($urandom_range(0, 999) < 3);
        cycle(w, 8'($urandom), r, f, ec, rs);
      end
    end

    idle();
    idle();
    chk("scoreboard.drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
